// File: rtl/alu_pkg.sv
// Shared types for the ALU result capture stage: per-entry flag bundle,
// entry record and skid FIFO occupancy states.
package alu_pkg;

   localparam int ALU_W = 32;

   typedef struct packed {
      logic of;
      logic cary;
      logic eq;
      logic zero;
      logic neg;
   } alu_flags_t;

   typedef struct packed {
      logic [ALU_W-1:0] s;
      alu_flags_t       flags;
   } alu_entry_t;

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_FULL  = 2'd2
   } occ_state_t;

endpackage

// File: rtl/alu_result_stage_sat_counter.sv
// Saturating event counter with synchronous clear; clear wins over a
// same-cycle increment and the count holds at all-ones instead of wrapping.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != {CNT_W{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/alu_result_stage.sv
// ALU result capture stage: 2-entry skid FIFO with derived zero/neg flags and
// an overflow event counter. Define STICKY_FLAGS_EN to add sticky_of/sticky_cary.
module alu_result_stage
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_W,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_s,
   input  logic             in_of,
   input  logic             in_cary,
   input  logic             in_eq,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_s,
   output logic             out_of,
   output logic             out_cary,
   output logic             out_eq,
   output logic             out_zero,
   output logic             out_neg,
   input  logic             clr_stats,
`ifdef STICKY_FLAGS_EN
   output logic             sticky_of,
   output logic             sticky_cary,
`endif
   output logic [CNT_W-1:0] ovf_count
);

   occ_state_t       state;
   logic             wr_ptr, rd_ptr;
   logic             push, pop;
   logic [WIDTH-1:0] mem_s [2];
   alu_flags_t       mem_f [2];
   alu_flags_t       cap_f;
   alu_flags_t       head_f;

   assign push      = in_valid & in_ready;
   assign out_valid = (state != OCC_EMPTY);
   assign pop       = out_valid & out_ready;

   // in_ready is registered from the next occupancy, so out_ready never reaches it combinationally
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= OCC_EMPTY;
         in_ready <= 1'b0;
         wr_ptr   <= 1'b0;
         rd_ptr   <= 1'b0;
      end else begin
         in_ready <= 1'b1;
         if (push) wr_ptr <= ~wr_ptr;
         if (pop)  rd_ptr <= ~rd_ptr;
         unique case (state)
            OCC_EMPTY: if (push) state <= OCC_ONE;
            OCC_ONE: begin
               if (push && !pop) begin
                  state    <= OCC_FULL;
                  in_ready <= 1'b0;
               end else if (pop && !push) begin
                  state <= OCC_EMPTY;
               end
            end
            OCC_FULL: begin
               if (pop) state <= OCC_ONE;
               else     in_ready <= 1'b0;
            end
            default: state <= OCC_EMPTY;
         endcase
      end
   end

   always_comb begin
      cap_f      = '0;
      cap_f.of   = in_of;
      cap_f.cary = in_cary;
      cap_f.eq   = in_eq;
      cap_f.zero = (in_s == '0);
      cap_f.neg  = in_s[WIDTH-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            mem_s[i] <= '0;
            mem_f[i] <= '0;
         end
      end else if (push) begin
         mem_s[wr_ptr] <= in_s;
         mem_f[wr_ptr] <= cap_f;
      end
   end

   assign head_f   = out_valid ? mem_f[rd_ptr] : '0;
   assign out_s    = out_valid ? mem_s[rd_ptr] : '0;
   assign out_of   = head_f.of;
   assign out_cary = head_f.cary;
   assign out_eq   = head_f.eq;
   assign out_zero = head_f.zero;
   assign out_neg  = head_f.neg;

   sat_counter #(.CNT_W(CNT_W)) u_ovf_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (push & in_of),
      .clr   (clr_stats),
      .count (ovf_count)
   );

`ifdef STICKY_FLAGS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sticky_of   <= 1'b0;
         sticky_cary <= 1'b0;
      end else if (clr_stats) begin
         sticky_of   <= 1'b0;
         sticky_cary <= 1'b0;
      end else if (push) begin
         sticky_of   <= sticky_of | in_of;
         sticky_cary <= sticky_cary | in_cary;
      end
   end
`endif

endmodule
